// File: rtl/edge_detector_multi_if.sv
// edge_detector_multi_if: channel bundle for the multi-channel edge detector.
// The master side drives raw inputs, per-channel edge select and flag clears;
// the slave side (the detector) returns filtered levels, pulses and flags.
interface edge_detector_multi_if #(
    parameter int CH = 4
) ();
    logic [CH-1:0]   in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   flag;
    logic            any_flag;

    modport master (
        output in,
        output mode,
        output clr,
        input  level,
        input  pulse,
        input  flag,
        input  any_flag
    );

    modport slave (
        input  in,
        input  mode,
        input  clr,
        output level,
        output pulse,
        output flag,
        output any_flag
    );
endinterface

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: CH independent deglitching edge detectors.
// Each channel registers its input, accepts a level change only after
// FILT_CYCLES identical samples, emits a one-cycle pulse on the selected
// edge(s) and keeps a sticky flag until software clears it.
// Optional macro EDGE_DETECTOR_SYNC_EN inserts a two-flop synchroniser in
// front of the sample register for inputs that are asynchronous to clk.
module edge_detector_multi #(
    parameter int CH          = 4,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    edge_detector_multi_if.slave bus
);

    typedef enum logic [1:0] {
        LO_STABLE = 2'b00,
        HI_CAND   = 2'b01,
        HI_STABLE = 2'b10,
        LO_CAND   = 2'b11
    } state_e;

    // Candidate count that completes a qualification window (cnt + 1 == FILT_CYCLES).
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               NO_FILTER = (FILT_CYCLES == 1);

    logic [CH-1:0]    samp_q,  samp_d;
    state_e           state_q [CH];
    state_e           state_d [CH];
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];
    logic [CH-1:0]    rise_ev;
    logic [CH-1:0]    fall_ev;
    logic [CH-1:0]    level_q, level_d;
    logic [CH-1:0]    pulse_q, pulse_d;
    logic [CH-1:0]    flag_q,  flag_d;

`ifdef EDGE_DETECTOR_SYNC_EN
    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;

    // Two-stage synchroniser so metastability settles before the sample register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.in;
            sync2_q <= sync1_q;
        end
    end

    // Sample register is fed from the synchroniser output.
    always_comb begin
        samp_d = sync2_q;
    end
`else
    // Inputs are already synchronous to clk, so they feed the sample register directly.
    always_comb begin
        samp_d = bus.in;
    end
`endif

    // Per-channel filter FSM: a candidate level must repeat FILT_CYCLES times to be accepted.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rise_ev[i] = 1'b0;
            fall_ev[i] = 1'b0;
            case (state_q[i])
                LO_STABLE: begin
                    if (samp_q[i]) begin
                        if (NO_FILTER) begin
                            state_d[i] = HI_STABLE;
                            cnt_d[i]   = '0;
                            rise_ev[i] = 1'b1;
                        end else begin
                            state_d[i] = HI_CAND;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                HI_CAND: begin
                    if (!samp_q[i]) begin
                        state_d[i] = LO_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == FILT_LAST) begin
                        state_d[i] = HI_STABLE;
                        cnt_d[i]   = '0;
                        rise_ev[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HI_STABLE: begin
                    if (!samp_q[i]) begin
                        if (NO_FILTER) begin
                            state_d[i] = LO_STABLE;
                            cnt_d[i]   = '0;
                            fall_ev[i] = 1'b1;
                        end else begin
                            state_d[i] = LO_CAND;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                LO_CAND: begin
                    if (samp_q[i]) begin
                        state_d[i] = HI_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == FILT_LAST) begin
                        state_d[i] = LO_STABLE;
                        cnt_d[i]   = '0;
                        fall_ev[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = LO_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Output next-state: level follows the accepted state, pulse is gated by the
    // live mode bits, and a new pulse always wins over a same-cycle clear.
    always_comb begin
        level_d = '0;
        pulse_d = '0;
        flag_d  = '0;
        for (int i = 0; i < CH; i++) begin
            level_d[i] = (state_d[i] == HI_STABLE) || (state_d[i] == LO_CAND);
            pulse_d[i] = (rise_ev[i] & bus.mode[2*i]) | (fall_ev[i] & bus.mode[2*i+1]);
            flag_d[i]  = pulse_d[i] | (flag_q[i] & ~bus.clr[i]);
        end
    end

    // State, counters and registered outputs; reset drops every channel to a quiet low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q  <= '0;
            level_q <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= LO_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            samp_q  <= samp_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.level    = level_q;
    assign bus.pulse    = pulse_q;
    assign bus.flag     = flag_q;
    assign bus.any_flag = |flag_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb_edge_detector_multi: directed scenarios plus random traffic for
// edge_detector_multi, checked every cycle against a sliding-window model.
// Honours EDGE_DETECTOR_SYNC_EN (adds two cycles of input latency).
module tb_edge_detector_multi;

    localparam int CH    = 4;
    localparam int FILT  = 3;
    localparam int CNT_W = 8;
`ifdef EDGE_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int HD = FILT + LAT;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    edge_detector_multi_if #(.CH(CH)) bus ();

    edge_detector_multi #(
        .CH(CH),
        .FILT_CYCLES(FILT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: hist[k] holds the input vector sampled k edges ago.
    // A channel accepts a new level when every sample in its window
    // (k = 1+LAT .. FILT+LAT) differs from the currently accepted level.
    logic [CH-1:0] hist [1:HD];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_pulse;
    logic [CH-1:0] m_flag;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= HD; k++) hist[k] = '0;
        m_level = '0;
        m_pulse = '0;
        m_flag  = '0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] now_in;
        logic          ev;
        logic          p;
        now_in = bus.in;
        for (int c = 0; c < CH; c++) begin
            ev = 1'b1;
            for (int k = 1 + LAT; k <= HD; k++)
                if (hist[k][c] === m_level[c]) ev = 1'b0;
            p = 1'b0;
            if (ev) begin
                p = m_level[c] ? bus.mode[2*c+1] : bus.mode[2*c];
                m_level[c] = ~m_level[c];
            end
            m_pulse[c] = p;
            m_flag[c]  = p | (m_flag[c] & ~bus.clr[c]);
        end
        for (int k = HD; k > 1; k--) hist[k] = hist[k-1];
        hist[1] = now_in;
    endtask

    task automatic check_all(input string tag);
        check_output({tag, "_level"}, 32'(bus.level), 32'(m_level));
        check_output({tag, "_pulse"}, 32'(bus.pulse), 32'(m_pulse));
        check_output({tag, "_flag"},  32'(bus.flag),  32'(m_flag));
        check_output({tag, "_any"},   32'(bus.any_flag), 32'(m_flag != '0));
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later.
    task automatic apply_stimulus(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Step until pulse[ch] rises; n = steps after the first one (-1 on timeout).
    task automatic wait_pulse(input int ch, input int bound, input string tag, output int n);
        n = -1;
        for (int i = 0; i < bound; i++) begin
            apply_stimulus(tag);
            if (bus.pulse[ch] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int cnt;
    int mode_exp [4] = '{0, 1, 1, 2};

    initial begin
        bus.in   = '0;
        bus.mode = 8'b01_01_01_01;
        bus.clr  = '0;
        reset    = 1'b0;
        model_reset();

        // Reset held: everything quiet.
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("idle");
        apply_stimulus("idle");

        // Clean rise on channel 0.
        bus.in = 4'b0001;
        wait_pulse(0, 20, "rise", n);
        check_output("rise_latency", 32'(n), 32'(FILT + LAT));
        check_output("rise_level0", 32'(bus.level[0]), 32'd1);
        apply_stimulus("rise_after");
        check_output("rise_pulse_width", 32'(bus.pulse[0]), 32'd0);
        check_output("rise_flag0", 32'(bus.flag[0]), 32'd1);
        check_output("rise_any", 32'(bus.any_flag), 32'd1);
        check_output("rise_others", 32'(bus.level[3:1]), 32'd0);

        // Glitch on channel 1: two samples high is one short of acceptance.
        cnt = 0;
        bus.in[1] = 1'b1;
        apply_stimulus("glitch");
        cnt += int'(bus.pulse[1]);
        apply_stimulus("glitch");
        cnt += int'(bus.pulse[1]);
        bus.in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus("glitch");
            cnt += int'(bus.pulse[1]);
        end
        check_output("glitch_pulses", 32'(cnt), 32'd0);
        check_output("glitch_level1", 32'(bus.level[1]), 32'd0);

        // Mode coverage on channel 2.
        for (int m = 0; m < 4; m++) begin
            bus.mode[5:4] = 2'(m);
            cnt = 0;
            bus.in[2] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                apply_stimulus("mode");
                cnt += int'(bus.pulse[2]);
            end
            check_output("mode_level_hi", 32'(bus.level[2]), 32'd1);
            bus.in[2] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                apply_stimulus("mode");
                cnt += int'(bus.pulse[2]);
            end
            check_output("mode_level_lo", 32'(bus.level[2]), 32'd0);
            check_output("mode_pulse_count", 32'(cnt), 32'(mode_exp[m]));
        end

        // Flag set/clear collision on channel 3.
        bus.mode[7:6] = 2'b01;
        bus.clr = '1;
        apply_stimulus("clr_all");
        bus.clr = 4'b1000;
        bus.in[3] = 1'b1;
        wait_pulse(3, 20, "collide", n);
        check_output("collide_latency", 32'(n), 32'(FILT + LAT));
        check_output("collide_flag3", 32'(bus.flag[3]), 32'd1);
        apply_stimulus("collide_clear");
        check_output("clear_flag3", 32'(bus.flag[3]), 32'd0);
        check_output("clear_any", 32'(bus.any_flag), 32'd0);
        bus.clr = '0;

        // Reset in the middle of a channel-0 rise candidate.
        bus.in[0] = 1'b0;
        for (int i = 0; i < 8; i++) apply_stimulus("ch0_low");
        bus.in[0] = 1'b1;
        apply_stimulus("cand");
        apply_stimulus("cand");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        check_output("midreset_level", 32'(bus.level), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_pulse(0, 20, "post_reset", n);
        check_output("post_reset_latency", 32'(n), 32'(FILT + LAT));

        // Random traffic: slowly changing inputs, occasional mode changes and clears.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) bus.in[c] = ~bus.in[c];
                bus.clr[c] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(39) == 0) bus.mode = 8'($urandom);
            apply_stimulus("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Parameterised, multi-channel successor to the single-channel edge-detector FSM.
- Each channel registers its input and deglitches it: a level change is accepted only after it has been stable for FILT_CYCLES samples.
- Each channel raises a one-cycle pulse on rising, falling or both edges, selected per channel at run time, and keeps a sticky event flag that software clears.
- Sits between raw external/status inputs and the control FSMs or interrupt logic.

Parameters:
- CH, 4, number of independent channels (1..32).
- FILT_CYCLES, 3, consecutive identical samples required to accept a level change (1..255; 1 = no filtering).
- CNT_W, 8, filter counter width; must satisfy 2**CNT_W > FILT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- in  input  CH  raw channel inputs.
- mode  input  2*CH  per-channel edge select, bits [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both.
- clr  input  CH  per-channel sticky-flag clear, level-sensitive, sampled each clock.
- level  output  CH  filtered (accepted) level per channel, registered.
- pulse  output  CH  one-cycle edge pulse per channel, registered.
- flag  output  CH  sticky event flag per channel, registered.
- any_flag  output  1  OR of all flag bits, combinational from flag registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - samp, level, pulse and flag all go to 0.
  - Every channel FSM goes to LO_STABLE with its counter at 0.
  - All outputs stay 0 until the first clock edge after reset returns to 1.
- Input stage: samp[i] <= in[i] every clock (one register; see Optional Feature).
- Per-channel FSM: 4 states, LO_STABLE, HI_CAND, HI_STABLE, LO_CAND.
  - level = 0 in LO_STABLE and HI_CAND; level = 1 in HI_STABLE and LO_CAND.
- LO_STABLE:
  - samp=0: stay.
  - samp=1 and FILT_CYCLES=1: go to HI_STABLE and raise a rise event.
  - samp=1 and FILT_CYCLES>1: go to HI_CAND with cnt=1.
- HI_CAND:
  - samp=0: go to LO_STABLE with cnt=0 (glitch rejected, no event).
  - samp=1 and cnt+1==FILT_CYCLES: go to HI_STABLE with cnt=0 and raise a rise event.
  - samp=1 otherwise: cnt<=cnt+1.
- HI_STABLE and LO_CAND: mirror images of LO_STABLE and HI_CAND with polarities swapped; acceptance raises a fall event.
- Latency:
  - Input first sampled high at edge t0 and held through edge t0+FILT_CYCLES-1 gives level=1 and pulse=1 from edge t0+FILT_CYCLES.
  - pulse lasts exactly one cycle.
- pulse[i] <= (rise event & mode[2i]) | (fall event & mode[2i+1]).
- Mode rules:
  - Filtering and level tracking run regardless of mode; mode=00 only suppresses pulse.
  - A mode change takes effect for events accepted on the same clock edge mode is sampled.
- Back-to-back edges:
  - Minimum accepted edge spacing is FILT_CYCLES cycles.
  - A toggle every cycle with FILT_CYCLES>1 produces no events.
- Flag:
  - flag[i] <= pulse_next[i] | (flag[i] & ~clr[i]).
  - Event and clr on the same edge: set wins, flag stays 1.
  - clr held high suppresses nothing except retention.
- Reset mid-operation: candidate counts are discarded. An input still high after reset release produces a rise event FILT_CYCLES cycles later, intentionally.
- Channels are fully independent; no cross-channel priority.

Optional Feature:
- Macro: EDGE_DETECTOR_SYNC_EN.
- Defined:
  - Two metastability flops (sync1, sync2, reset to 0) are inserted before samp.
  - All latencies grow by 2 cycles.
  - Use for asynchronous inputs.
- Undefined: in is assumed synchronous to clk and feeds samp directly.

Test Plan:
- Reset and clean rise: CH=4, FILT_CYCLES=3, mode=8'b01_01_01_01. Assert reset=0, release, in=4'b0001 held from edge t0 -> level[0]=1 and a one-cycle pulse[0] at edge t0+3, then flag[0]=1 and any_flag=1; other channels stay 0.
- Glitch rejection: ch1 in=1 for 2 cycles then 0, FILT_CYCLES=3 -> no pulse, level[1] stays 0, FSM back in LO_STABLE.
- Mode coverage: on ch2, drive rise then fall edges (each held 5 cycles) under mode 00, 01, 10 and 11 -> pulse counts 0, 1 (rise), 1 (fall), 2; level toggles in all four cases.
- Flag set/clear collision: clr[3]=1 on the same edge pulse[3] fires -> flag[3]=1. clr[3]=1 on the next edge with no event -> flag[3]=0, any_flag=0.
- Reset mid-candidate: ch0 high for 2 samples, assert reset asynchronously between edges -> outputs 0 immediately. With in still high after release -> pulse[0] exactly 3 cycles after the first post-reset sample.
- EDGE_DETECTOR_SYNC_EN defined: repeat the clean-rise scenario -> pulse at edge t0+5; the glitch and mode scenarios give identical outcomes, shifted by 2 cycles.
